// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//
// Upstream control stage for the 7-tap FIR. It takes framed bytes from the
// UART receiver, validates each frame and holds the accepted values in a
// pending register. Pending values reach the FIR only on sample_tick, so the
// coefficients never change in the middle of a sample.
//
// Frame formats:
//   coefficient frame : HDR_COEF, 14 data bytes (MSB first), XOR checksum
//   enable frame      : HDR_EN, one byte (8'h00 = bypass, 8'h01 = filter)
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low (0 = reset)
//   rx_data      received byte, valid while rx_valid is high
//   rx_valid     one-cycle byte strobe
//   sample_tick  FIR sample strobe; pending values are applied on it
//   eff          active coefficients, coeff1 in [111:96], coeff7 in [15:0]
//   en           active filter enable, 0 = bypass
//   busy         high while a frame is in progress
//   coeff_update one-cycle pulse after pending values are applied
//   frame_err    one-cycle pulse when a frame is rejected
// -----------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter logic [111:0] DEFAULT_COEFF = 112'h0,
    parameter int unsigned  TIMEOUT       = 1000,
    parameter logic [7:0]   HDR_COEF      = 8'hA5,
    parameter logic [7:0]   HDR_EN        = 8'h5A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         sample_tick,
    output logic [111:0] eff,
    output logic         en,
    output logic         busy,
    output logic         coeff_update,
    output logic         frame_err
);

    localparam int unsigned GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        COEF,
        CSUM,
        ENA
    } state_t;

    state_t         state;
    logic [111:0]   shadow;
    logic [7:0]     csum;
    logic [3:0]     byte_idx;
    logic [GW-1:0]  gap;
    logic [111:0]   pend_coeff;
    logic           pend_c_flag;
    logic           pend_en;
    logic           pend_e_flag;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shadow       <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            gap          <= '0;
            pend_coeff   <= '0;
            pend_c_flag  <= 1'b0;
            pend_en      <= 1'b0;
            pend_e_flag  <= 1'b0;
            eff          <= DEFAULT_COEFF;
            en           <= 1'b0;
            coeff_update <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err    <= 1'b0;
            coeff_update <= 1'b0;

            // Apply whatever was committed before this edge. The frame logic
            // below is written later in the block, so a commit on the same
            // cycle re-sets its flag and waits for the following tick.
            if (sample_tick && (pend_c_flag || pend_e_flag)) begin
                if (pend_c_flag) begin
                    eff <= pend_coeff;
                end
                if (pend_e_flag) begin
                    en <= pend_en;
                end
                pend_c_flag  <= 1'b0;
                pend_e_flag  <= 1'b0;
                coeff_update <= 1'b1;
            end

            if (state != IDLE && !rx_valid) begin
                // Inter-byte gap; a byte on the expiry cycle takes the
                // other branch and is accepted.
                if (gap == GAP_LAST) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    shadow    <= '0;
                    csum      <= '0;
                    byte_idx  <= '0;
                    gap       <= '0;
                end else begin
                    gap <= gap + 1'b1;
                end
            end else begin
                gap <= '0;
                if (rx_valid) begin
                    case (state)
                        IDLE: begin
                            if (rx_data == HDR_COEF) begin
                                state    <= COEF;
                                byte_idx <= '0;
                                csum     <= '0;
                            end else if (rx_data == HDR_EN) begin
                                state <= ENA;
                            end
                        end
                        COEF: begin
                            // Shifting in from the bottom leaves byte 0 in
                            // [111:104] once all 14 bytes are in.
                            shadow <= {shadow[103:0], rx_data};
                            csum   <= csum ^ rx_data;
                            if (byte_idx == 4'd13) begin
                                state    <= CSUM;
                                byte_idx <= '0;
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                            end
                        end
                        CSUM: begin
                            if (rx_data == csum) begin
                                pend_coeff  <= shadow;
                                pend_c_flag <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        ENA: begin
                            if (rx_data[7:1] == 7'd0) begin
                                pend_en     <= rx_data[0];
                                pend_e_flag <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
//
// Directed bench for fir_coeff_loader. Inputs change and outputs are checked
// on the falling clock edge; pulse outputs are also counted on every rising
// edge so that missing or duplicated pulses are visible.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

    localparam int unsigned  TO     = 20;
    localparam logic [111:0] TB_DEF = 112'hDEADBEEF00001111222233334444;
    localparam logic [111:0] E1     = 112'h0102030405060708090A0B0C0D0E;
    localparam logic [111:0] E2     = 112'h101112131415161718191A1B1C1D;
    localparam logic [111:0] FA     = 112'h202122232425262728292A2B2C2D;
    localparam logic [111:0] FB     = 112'h303132333435363738393A3B3C3D;
    localparam logic [111:0] FC     = 112'h606162636465666768696A6B6C6D;

    logic         clk;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         sample_tick;
    logic [111:0] eff;
    logic         en;
    logic         busy;
    logic         coeff_update;
    logic         frame_err;

    int total;
    int bad;
    int cu_cnt;
    int fe_cnt;

    fir_coeff_loader #(
        .DEFAULT_COEFF (TB_DEF),
        .TIMEOUT       (TO),
        .HDR_COEF      (8'hA5),
        .HDR_EN        (8'h5A)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sample_tick  (sample_tick),
        .eff          (eff),
        .en           (en),
        .busy         (busy),
        .coeff_update (coeff_update),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values read here are the ones held during the cycle that just ended.
    always @(posedge clk) begin
        if (coeff_update === 1'b1) cu_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    // All tasks start and end on a falling edge.
    task automatic put(input logic [7:0] b, input logic tick);
        rx_data     = b;
        rx_valid    = 1'b1;
        sample_tick = tick;
        @(negedge clk);
        rx_valid    = 1'b0;
        sample_tick = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic send_coef(input logic [111:0] v);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        put(8'hA5, 1'b0);
        for (int i = 0; i < 14; i++) begin
            b  = v[111 - 8*i -: 8];
            cs = cs ^ b;
            put(b, 1'b0);
        end
        put(cs, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sample_tick = 1'b0;
        idle(2);
        total++; if (eff !== TB_DEF) begin bad++; $display("FAIL reset_eff: got %h want %h", eff, TB_DEF); end
        total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (coeff_update !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: got cu=%b fe=%b want 0 0", coeff_update, frame_err);
        end
        reset = 1'b1;
        cu_cnt = 0; fe_cnt = 0;
        idle(5);
        total++; if (cu_cnt !== 0 || fe_cnt !== 0) begin
            bad++; $display("FAIL release_pulses: got cu=%0d fe=%0d want 0 0", cu_cnt, fe_cnt);
        end
    endtask

    task automatic test_coef_frame();
        int cu0;
        cu0 = cu_cnt;
        put(8'hA5, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL coef_busy: got %b want 1", busy); end
        for (int i = 1; i <= 14; i++) put(8'(i), 1'b0);
        put(8'h0F, 1'b0);
        idle(5);
        total++; if (eff !== TB_DEF) begin bad++; $display("FAIL coef_before_tick: got %h want %h", eff, TB_DEF); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coef_busy_done: got %b want 0", busy); end
        tick();
        total++; if (eff !== E1) begin bad++; $display("FAIL coef_applied: got %h want %h", eff, E1); end
        total++; if (coeff_update !== 1'b1) begin bad++; $display("FAIL coef_update_pulse: got %b want 1", coeff_update); end
        idle(1);
        total++; if (coeff_update !== 1'b0) begin bad++; $display("FAIL coef_update_width: got %b want 0", coeff_update); end
        tick();
        idle(2);
        total++; if (cu_cnt !== cu0 + 1) begin bad++; $display("FAIL coef_update_count: got %0d want %0d", cu_cnt, cu0 + 1); end
    endtask

    task automatic test_bad_csum();
        int fe0;
        int cu0;
        fe0 = fe_cnt; cu0 = cu_cnt;
        put(8'hA5, 1'b0);
        for (int i = 1; i <= 14; i++) put(8'(i ^ 8'h80), 1'b0);
        put(8'h00, 1'b0);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL csum_err_pulse: got %b want 1", frame_err); end
        idle(2);
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL csum_err_count: got %0d want %0d", fe_cnt, fe0 + 1); end
        tick(); tick(); tick();
        idle(2);
        total++; if (eff !== E1 || en !== 1'b0) begin bad++; $display("FAIL csum_unchanged: got %h en=%b want %h en=0", eff, en, E1); end
        total++; if (cu_cnt !== cu0) begin bad++; $display("FAIL csum_no_update: got %0d want %0d", cu_cnt, cu0); end
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        put(8'hA5, 1'b0);
        for (int i = 1; i <= 6; i++) put(8'(i), 1'b0);
        idle(TO - 1);
        total++; if (busy !== 1'b1 || frame_err !== 1'b0) begin
            bad++; $display("FAIL timeout_early: got busy=%b fe=%b want 1 0", busy, frame_err);
        end
        idle(1);
        total++; if (frame_err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_fire: got fe=%b busy=%b want 1 0", frame_err, busy);
        end
        idle(1);
        // Byte landing exactly on the expiry cycle must be accepted.
        put(8'hA5, 1'b0);
        put(8'h10, 1'b0); put(8'h11, 1'b0); put(8'h12, 1'b0);
        idle(TO - 1);
        for (int i = 8'h13; i <= 8'h1D; i++) put(8'(i), 1'b0);
        put(8'h01, 1'b0);
        idle(2);
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL timeout_err_count: got %0d want %0d", fe_cnt, fe0 + 1); end
        tick();
        total++; if (eff !== E2) begin bad++; $display("FAIL timeout_next_frame: got %h want %h", eff, E2); end
    endtask

    task automatic test_enable();
        int fe0;
        put(8'h5A, 1'b0);
        put(8'h01, 1'b1);
        total++; if (en !== 1'b0 || coeff_update !== 1'b0) begin
            bad++; $display("FAIL en_same_tick: got en=%b cu=%b want 0 0", en, coeff_update);
        end
        idle(2);
        tick();
        total++; if (en !== 1'b1 || coeff_update !== 1'b1) begin
            bad++; $display("FAIL en_next_tick: got en=%b cu=%b want 1 1", en, coeff_update);
        end
        total++; if (eff !== E2) begin bad++; $display("FAIL en_eff_kept: got %h want %h", eff, E2); end
        fe0 = fe_cnt;
        put(8'h5A, 1'b0);
        put(8'h02, 1'b0);
        idle(2);
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL en_bad_value: got %0d want %0d", fe_cnt, fe0 + 1); end
        tick();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL en_bad_kept: got %b want 1", en); end
        put(8'h5A, 1'b0);
        put(8'h00, 1'b0);
        tick();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL en_bypass: got %b want 0", en); end
    endtask

    task automatic test_last_wins_reset();
        int cu0;
        logic [7:0] cs;
        send_coef(FA);
        send_coef(FB);
        idle(2);
        total++; if (eff !== E2) begin bad++; $display("FAIL lw_before_tick: got %h want %h", eff, E2); end
        tick();
        total++; if (eff !== FB) begin bad++; $display("FAIL lw_last_wins: got %h want %h", eff, FB); end
        put(8'h5A, 1'b0);
        put(8'h01, 1'b0);
        tick();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL lw_en_set: got %b want 1", en); end
        // Apply proceeds while another frame is mid-flight.
        send_coef(FC);
        put(8'hA5, 1'b0);
        cs = 8'h00;
        for (int i = 8'h40; i <= 8'h43; i++) begin cs = cs ^ 8'(i); put(8'(i), 1'b0); end
        tick();
        total++; if (eff !== FC || busy !== 1'b1) begin
            bad++; $display("FAIL lw_apply_midframe: got %h busy=%b want %h busy=1", eff, busy, FC);
        end
        for (int i = 8'h44; i <= 8'h4D; i++) begin cs = cs ^ 8'(i); put(8'(i), 1'b0); end
        put(cs, 1'b0);
        put(8'hA5, 1'b0);
        put(8'h50, 1'b0);
        put(8'h51, 1'b0);
        reset = 1'b0;
        #1;
        total++; if (eff !== TB_DEF || en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL lw_reset_async: got %h en=%b busy=%b want %h 0 0", eff, en, busy, TB_DEF);
        end
        @(negedge clk);
        reset = 1'b1;
        cu0 = cu_cnt;
        idle(2);
        tick();
        idle(2);
        total++; if (eff !== TB_DEF) begin bad++; $display("FAIL lw_pending_dropped: got %h want %h", eff, TB_DEF); end
        total++; if (cu_cnt !== cu0 || busy !== 1'b0) begin
            bad++; $display("FAIL lw_after_reset: got cu=%0d busy=%b want %0d 0", cu_cnt, busy, cu0);
        end
    endtask

    initial begin
        total = 0; bad = 0; cu_cnt = 0; fe_cnt = 0;
        test_reset();
        test_coef_frame();
        test_bad_csum();
        test_timeout();
        test_enable();
        test_last_wins_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
